// File: rtl/ascon_pkg.sv
// ascon_pkg: shared constants, FSM state type and rate-word padding helper
// for the Ascon-Hash sponge controller.
//
// Build option: ASCON_HASHA_EN selects the Ascon-Hasha IV and 8-round
// absorb/squeeze permutations. If it is undefined, the design uses the
// Ascon-Hash IV with 12 rounds.
package ascon_pkg;

  localparam int unsigned RATE_BITS  = 64;
  localparam int unsigned STATE_BITS = 320;

  localparam logic [STATE_BITS-1:0] IV_HASH = {
    64'hee9398aadb67f03d, 64'h8bb21831c60f1002, 64'hb48a92db98d5da62,
    64'h43189921b8f8e3e8, 64'h348fa5c9d525e140
  };

  localparam logic [STATE_BITS-1:0] IV_HASHA = {
    64'h01470194fc6528a6, 64'h738ec38ac0adffa7, 64'h2ec8e3296c76384c,
    64'hd6f6a54d7f52377d, 64'ha13c42a223be8d87
  };

`ifdef ASCON_HASHA_EN
  localparam bit HASHA_EN = 1'b1;
`else
  localparam bit HASHA_EN = 1'b0;
`endif

  localparam logic [STATE_BITS-1:0] IV           = HASHA_EN ? IV_HASHA : IV_HASH;
  localparam int unsigned           ROUNDS_B_DEF = HASHA_EN ? 8 : 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PERM_WAIT,
    ST_PAD,
    ST_FINAL_WAIT,
    ST_SQUEEZE,
    ST_SQ_WAIT
  } state_e;

  // Keeps the first nbytes bytes (byte 0 is the MSB byte) and places the
  // 0x80 pad marker at byte nbytes. An nbytes value of 8 or more returns the
  // data unchanged.
  function automatic logic [RATE_BITS-1:0] pad_word(input logic [RATE_BITS-1:0] data,
                                                    input logic [3:0]           nbytes);
    logic [RATE_BITS-1:0] keep;
    logic [RATE_BITS-1:0] pad;
    keep = '1;
    pad  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i >= 32'(nbytes)) keep[63-8*i -: 8] = '0;
      if (i == 32'(nbytes)) pad[63-8*i -: 8]  = 8'h80;
    end
    return (data & keep) | pad;
  endfunction

endpackage

// File: rtl/ascon_hash_ctrl_if.sv
// ascon_hash_ctrl_if: message-in and digest-out handshakes of the hash
// controller.
//   msg_*: valid/ready message words. msg_bytes applies to the last word only.
//   dig_*: valid/ready digest words. dig_last marks the final word.
// modport master: message source / digest sink side.
// modport slave : controller side.
interface ascon_hash_ctrl_if;
  import ascon_pkg::*;

  logic                 msg_valid;
  logic                 msg_ready;
  logic [RATE_BITS-1:0] msg_data;
  logic                 msg_last;
  logic [3:0]           msg_bytes;
  logic                 dig_valid;
  logic                 dig_ready;
  logic [RATE_BITS-1:0] dig_data;
  logic                 dig_last;

  modport master (
    output msg_valid, msg_data, msg_last, msg_bytes, dig_ready,
    input  msg_ready, dig_valid, dig_data, dig_last
  );

  modport slave (
    input  msg_valid, msg_data, msg_last, msg_bytes, dig_ready,
    output msg_ready, dig_valid, dig_data, dig_last
  );
endinterface

// File: rtl/ascon_hash_ctrl.sv
// ascon_hash_ctrl: Ascon-Hash sponge sequencer. It owns the 320-bit state,
// absorbs 64-bit rate words with padding, and drives an external permutation
// engine. After the final permutation it squeezes HASH_WORDS digest words.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   bus           : message/digest handshakes (ascon_hash_ctrl_if.slave)
//   perm_start    : one-cycle launch pulse; perm_rounds gives the round count
//   perm_state_o  : registered sponge state {x0..x4}, x0 in the MSBs
//   perm_done     : engine result strobe; perm_state_i carries the result
//   busy          : high whenever the FSM is not idle
// Build option: ASCON_HASHA_EN (see ascon_pkg) selects the Hasha variant.
module ascon_hash_ctrl
  import ascon_pkg::*;
#(
  parameter int unsigned HASH_WORDS = 4,
  parameter int unsigned ROUNDS_A   = 12,
  parameter int unsigned ROUNDS_B   = ROUNDS_B_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  ascon_hash_ctrl_if.slave      bus,
  output logic                  perm_start,
  output logic [3:0]            perm_rounds,
  output logic [STATE_BITS-1:0] perm_state_o,
  input  logic                  perm_done,
  input  logic [STATE_BITS-1:0] perm_state_i,
  output logic                  busy
);

  localparam int unsigned          CNT_W     = (HASH_WORDS > 1) ? $clog2(HASH_WORDS) : 1;
  localparam logic [CNT_W-1:0]     LAST_WORD = CNT_W'(HASH_WORDS - 1);
  localparam logic [RATE_BITS-1:0] PAD_FULL  = {8'h80, 56'h0};
  localparam int unsigned          X0_MSB    = STATE_BITS - 1;

  state_e                  state_q, state_d;
  logic [STATE_BITS-1:0]   s_q, s_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pad_q, pad_d;
  logic                    start_q, start_d;
  logic [3:0]              rounds_q, rounds_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= IV;
      cnt_q    <= '0;
      pad_q    <= 1'b0;
      start_q  <= 1'b0;
      rounds_q <= 4'(ROUNDS_B);
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      pad_q    <= pad_d;
      start_q  <= start_d;
      rounds_q <= rounds_d;
    end
  end

  // IDLE accepts the first word exactly as ABSORB would. The FSM then moves
  // straight to the wait state that the word selects.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    pad_d    = pad_q;
    start_d  = 1'b0;
    rounds_d = rounds_q;
    unique case (state_q)
      ST_IDLE, ST_ABSORB: begin
        if (bus.msg_valid) begin
          start_d = 1'b1;
          if (!bus.msg_last) begin
            s_d[X0_MSB -: RATE_BITS] = s_q[X0_MSB -: RATE_BITS] ^ bus.msg_data;
            rounds_d = 4'(ROUNDS_B);
            state_d  = ST_PERM_WAIT;
          end else if (bus.msg_bytes < 4'd8) begin
            s_d[X0_MSB -: RATE_BITS] = s_q[X0_MSB -: RATE_BITS] ^
                                       pad_word(bus.msg_data, bus.msg_bytes);
            rounds_d = 4'(ROUNDS_A);
            state_d  = ST_FINAL_WAIT;
          end else begin
            // A full last word needs an extra block that holds only padding.
            s_d[X0_MSB -: RATE_BITS] = s_q[X0_MSB -: RATE_BITS] ^ bus.msg_data;
            rounds_d = 4'(ROUNDS_B);
            pad_d    = 1'b1;
            state_d  = ST_PERM_WAIT;
          end
        end
      end
      ST_PERM_WAIT: begin
        if (perm_done) begin
          s_d     = perm_state_i;
          state_d = pad_q ? ST_PAD : ST_ABSORB;
        end
      end
      ST_PAD: begin
        s_d[X0_MSB -: RATE_BITS] = s_q[X0_MSB -: RATE_BITS] ^ PAD_FULL;
        start_d  = 1'b1;
        rounds_d = 4'(ROUNDS_A);
        pad_d    = 1'b0;
        state_d  = ST_FINAL_WAIT;
      end
      ST_FINAL_WAIT: begin
        if (perm_done) begin
          s_d     = perm_state_i;
          state_d = ST_SQUEEZE;
        end
      end
      ST_SQUEEZE: begin
        if (bus.dig_ready) begin
          if (cnt_q == LAST_WORD) begin
            s_d     = IV;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d    = cnt_q + 1'b1;
            start_d  = 1'b1;
            rounds_d = 4'(ROUNDS_B);
            state_d  = ST_SQ_WAIT;
          end
        end
      end
      ST_SQ_WAIT: begin
        if (perm_done) begin
          s_d     = perm_state_i;
          state_d = ST_SQUEEZE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The controller does not advertise msg_ready during reset, because reset
  // would discard any handshake in that cycle.
  always_comb begin
    bus.msg_ready = 1'b0;
    bus.dig_valid = 1'b0;
    bus.dig_data  = '0;
    bus.dig_last  = 1'b0;
    case (state_q)
      ST_IDLE, ST_ABSORB: bus.msg_ready = !rst;
      ST_SQUEEZE: begin
        bus.dig_valid = 1'b1;
        bus.dig_data  = s_q[X0_MSB -: RATE_BITS];
        bus.dig_last  = (cnt_q == LAST_WORD);
      end
      default: ;
    endcase
    busy         = (state_q != ST_IDLE);
    perm_start   = start_q;
    perm_rounds  = rounds_q;
    perm_state_o = s_q;
  end

endmodule

// File: tb/tb_ascon_hash_ctrl.sv
`timescale 1ns/1ps
module tb_ascon_hash_ctrl;

  localparam int RA = 12;
`ifdef ASCON_HASHA_EN
  localparam int RB = 8;
  localparam logic [319:0] TB_IV = {
    64'h01470194fc6528a6, 64'h738ec38ac0adffa7, 64'h2ec8e3296c76384c,
    64'hd6f6a54d7f52377d, 64'ha13c42a223be8d87
  };
`else
  localparam int RB = 12;
  localparam logic [319:0] TB_IV = {
    64'hee9398aadb67f03d, 64'h8bb21831c60f1002, 64'hb48a92db98d5da62,
    64'h43189921b8f8e3e8, 64'h348fa5c9d525e140
  };
`endif
  localparam logic [255:0] EMPTY_HASH_KAT =
    256'h7346bc14f036e87ae03d0997913088f5f68411434b3cf8b54fa796a80d251f91;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         perm_start;
  logic [3:0]   perm_rounds;
  logic [319:0] perm_state_o;
  logic         perm_done = 1'b0;
  logic [319:0] perm_state_i = '0;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  ascon_hash_ctrl_if bus();

  ascon_hash_ctrl #(.HASH_WORDS(4), .ROUNDS_A(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .perm_start   (perm_start),
    .perm_rounds  (perm_rounds),
    .perm_state_o (perm_state_o),
    .perm_done    (perm_done),
    .perm_state_i (perm_state_i),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference Ascon permutation ----------------
  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_p(input logic [319:0] s, input int rounds);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    for (int r = 12 - rounds; r < 12; r++) begin
      x2 = x2 ^ 64'(((15 - r) << 4) | r);
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x1 & x2; t1 = ~x2 & x3; t2 = ~x3 & x4; t3 = ~x4 & x0; t4 = ~x0 & x1;
      x0 = x0 ^ t0; x1 = x1 ^ t1; x2 = x2 ^ t2; x3 = x3 ^ t3; x4 = x4 ^ t4;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
      x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
      x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
      x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
      x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  // Sponge hash over a byte string: full blocks, then one padded block.
  function automatic logic [255:0] ref_hash(input logic [7:0] m[$]);
    logic [319:0] s;
    logic [63:0]  blk;
    logic [7:0]   b;
    logic [255:0] d;
    int n, pos;
    s = TB_IV; n = m.size(); pos = 0; d = '0;
    while (n - pos >= 8) begin
      blk = '0;
      for (int k = 0; k < 8; k++) blk = {blk[55:0], m[pos+k]};
      s[319:256] = s[319:256] ^ blk;
      s = ascon_p(s, RB);
      pos += 8;
    end
    blk = '0;
    for (int k = 0; k < 8; k++) begin
      if (pos + k < n)       b = m[pos+k];
      else if (pos + k == n) b = 8'h80;
      else                   b = 8'h00;
      blk = {blk[55:0], b};
    end
    s[319:256] = s[319:256] ^ blk;
    s = ascon_p(s, RA);
    for (int w = 0; w < 4; w++) begin
      d = {d[191:0], s[319:256]};
      if (w < 3) s = ascon_p(s, RB);
    end
    return d;
  endfunction

  // ---------------- behavioural permutation engine ----------------
  int           eng_lat = 2;
  logic         eng_busy = 1'b0;
  int           eng_cnt = 0;
  logic [319:0] eng_res = '0;
  int           launch_q[$];
  int           overlap_errs = 0;

  always @(posedge clk) begin
    perm_done <= 1'b0;
    if (eng_busy) begin
      if (eng_cnt <= 1) begin
        perm_done    <= 1'b1;
        perm_state_i <= eng_res;
        eng_busy     <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
    if (perm_start === 1'b1) begin
      if (eng_busy) overlap_errs = overlap_errs + 1;
      eng_busy <= 1'b1;
      eng_cnt  <= eng_lat;
      eng_res  <= ascon_p(perm_state_o, int'(perm_rounds));
      launch_q.push_back(int'(perm_rounds));
    end
  end

  // Number of logged launches that differ from the sponge schedule for an
  // n-byte message: n/8 absorb launches, the final launch, then 3 squeeze launches.
  function automatic int launch_mismatch(input int n);
    int exp_q[$];
    int bad;
    for (int i = 0; i < n / 8; i++) exp_q.push_back(RB);
    exp_q.push_back(RA);
    for (int i = 0; i < 3; i++) exp_q.push_back(RB);
    bad = (exp_q.size() != launch_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && i < launch_q.size(); i++)
      if (exp_q[i] != launch_q[i]) bad++;
    return bad;
  endfunction

  // ---------------- stimulus driver ----------------
  task automatic run_hash(input logic [7:0] m[$], input bit garbage, input int stall_word,
                          input int stall_len, output logic [255:0] dig, output int lat,
                          output logic [3:0] last_pat, output int stall_bad, output bit tmo);
    int n, nw, idx, cyc, sl;
    logic [63:0] word, d0;
    logic [7:0]  b;
    dig = '0; lat = 0; last_pat = '0; stall_bad = 0; tmo = 1'b0;
    launch_q.delete();
    n  = m.size();
    nw = (n == 0) ? 1 : (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      word = '0;
      for (int k = 0; k < 8; k++) begin
        idx = 8 * w + k;
        if (idx < n) b = m[idx];
        else         b = garbage ? 8'($urandom) : 8'h00;
        word = {word[55:0], b};
      end
      bus.msg_data  = word;
      bus.msg_last  = (w == nw - 1);
      bus.msg_bytes = (w == nw - 1) ? 4'(n - 8 * w) : 4'($urandom_range(0, 15));
      bus.msg_valid = 1'b1;
      cyc = 0;
      while (!bus.msg_ready && cyc < 200) begin @(posedge clk); #1; cyc++; end
      if (!bus.msg_ready) begin bus.msg_valid = 1'b0; tmo = 1'b1; return; end
      @(posedge clk); #1;
      bus.msg_valid = 1'b0;
      bus.msg_data  = {$urandom, $urandom};
    end
    cyc = 0;
    while (!bus.dig_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
    lat = cyc;
    for (int w = 0; w < 4; w++) begin
      cyc = 0;
      while (!bus.dig_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
      if (!bus.dig_valid) begin tmo = 1'b1; return; end
      d0 = bus.dig_data;
      sl = (w == stall_word) ? stall_len : $urandom_range(0, 1);
      for (int i = 0; i < sl; i++) begin
        @(posedge clk); #1;
        if (bus.dig_data !== d0 || bus.dig_valid !== 1'b1 || perm_start !== 1'b0) stall_bad++;
      end
      bus.dig_ready = 1'b1;
      dig = {dig[191:0], bus.dig_data};
      last_pat[w] = bus.dig_last;
      @(posedge clk); #1;
      bus.dig_ready = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.msg_ready !== 1'b0) begin failures++; $display("FAIL reset_msg_ready: got %b expected 0", bus.msg_ready); end
    checks++; if (bus.dig_valid !== 1'b0) begin failures++; $display("FAIL reset_dig_valid: got %b expected 0", bus.dig_valid); end
    checks++; if (bus.dig_last !== 1'b0) begin failures++; $display("FAIL reset_dig_last: got %b expected 0", bus.dig_last); end
    checks++; if (bus.dig_data !== 64'h0) begin failures++; $display("FAIL reset_dig_data: got %h expected 0", bus.dig_data); end
    checks++; if (perm_start !== 1'b0) begin failures++; $display("FAIL reset_perm_start: got %b expected 0", perm_start); end
    checks++; if (perm_rounds !== 4'(RB)) begin failures++; $display("FAIL reset_perm_rounds: got %0d expected %0d", perm_rounds, RB); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (perm_state_o !== TB_IV) begin failures++; $display("FAIL reset_state: got %h expected %h", perm_state_o, TB_IV); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.msg_ready !== 1'b1) begin failures++; $display("FAIL idle_msg_ready: got %b expected 1", bus.msg_ready); end
  endtask

  task automatic test_empty();
    logic [7:0] m[$];
    logic [255:0] dig, exp_d;
    logic [3:0] lp;
    int lat, sb; bit tmo;
    eng_lat = 3;
    exp_d = ref_hash(m);
    run_hash(m, 1'b1, -1, 0, dig, lat, lp, sb, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL empty_timeout: got timeout expected completion"); end
    checks++; if (dig !== exp_d) begin failures++; $display("FAIL empty_digest: got %h expected %h", dig, exp_d); end
`ifndef ASCON_HASHA_EN
    checks++; if (dig !== EMPTY_HASH_KAT) begin failures++; $display("FAIL empty_kat: got %h expected %h", dig, EMPTY_HASH_KAT); end
`endif
    checks++; if (lp !== 4'b1000) begin failures++; $display("FAIL empty_dig_last: got %b expected 1000", lp); end
    checks++; if (lat != eng_lat + 2) begin failures++; $display("FAIL empty_latency: got %0d expected %0d", lat, eng_lat + 2); end
    checks++; if (launch_mismatch(0) != 0) begin failures++; $display("FAIL empty_launch_rounds: got %0d bad launches expected 0", launch_mismatch(0)); end
  endtask

  task automatic test_full_word();
    logic [7:0] m[$];
    logic [255:0] dig, exp_d;
    logic [3:0] lp;
    int lat, sb; bit tmo;
    eng_lat = 2;
    for (int i = 0; i < 8; i++) m.push_back(8'($urandom));
    exp_d = ref_hash(m);
    run_hash(m, 1'b1, -1, 0, dig, lat, lp, sb, tmo);
    checks++; if (tmo || dig !== exp_d) begin failures++; $display("FAIL full_word_digest: got %h expected %h", dig, exp_d); end
    checks++; if (launch_mismatch(8) != 0) begin failures++; $display("FAIL full_word_launch_rounds: got %0d bad launches expected 0", launch_mismatch(8)); end
    checks++; if (lp !== 4'b1000) begin failures++; $display("FAIL full_word_dig_last: got %b expected 1000", lp); end
  endtask

  task automatic test_partial_garbage();
    logic [7:0] m[$];
    logic [255:0] dig_g, dig_z, exp_d;
    logic [3:0] lp;
    int lat, sb; bit tmo_g, tmo_z;
    eng_lat = 1;
    for (int i = 0; i < 19; i++) m.push_back(8'($urandom));
    exp_d = ref_hash(m);
    run_hash(m, 1'b1, -1, 0, dig_g, lat, lp, sb, tmo_g);
    run_hash(m, 1'b0, -1, 0, dig_z, lat, lp, sb, tmo_z);
    checks++; if (tmo_g || dig_g !== exp_d) begin failures++; $display("FAIL partial_garbage_digest: got %h expected %h", dig_g, exp_d); end
    checks++; if (tmo_z || dig_z !== exp_d) begin failures++; $display("FAIL partial_zero_digest: got %h expected %h", dig_z, exp_d); end
    checks++; if (launch_mismatch(19) != 0) begin failures++; $display("FAIL partial_launch_rounds: got %0d bad launches expected 0", launch_mismatch(19)); end
  endtask

  task automatic test_dig_stall();
    logic [7:0] m[$];
    logic [255:0] dig, exp_d;
    logic [3:0] lp;
    int lat, sb; bit tmo;
    eng_lat = 4;
    for (int i = 0; i < 11; i++) m.push_back(8'($urandom));
    exp_d = ref_hash(m);
    run_hash(m, 1'b1, 1, 10, dig, lat, lp, sb, tmo);
    checks++; if (sb != 0) begin failures++; $display("FAIL stall_stability: got %0d unstable cycles expected 0", sb); end
    checks++; if (tmo || dig !== exp_d) begin failures++; $display("FAIL stall_digest: got %h expected %h", dig, exp_d); end
    checks++; if (overlap_errs != 0) begin failures++; $display("FAIL start_overlap: got %0d expected 0", overlap_errs); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] m[$];
    logic [255:0] dig, exp_d;
    logic [3:0] lp;
    int lat, sb, cyc; bit tmo;
    eng_lat = 20;
    bus.msg_data = {$urandom, $urandom}; bus.msg_last = 1'b1; bus.msg_bytes = 4'd0;
    bus.msg_valid = 1'b1;
    cyc = 0;
    while (!bus.msg_ready && cyc < 200) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    bus.msg_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before_reset: got %b expected 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    checks++; if (perm_state_o !== TB_IV) begin failures++; $display("FAIL mid_reset_state: got %h expected %h", perm_state_o, TB_IV); end
    checks++; if (bus.msg_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_msg_ready: got %b expected 0", bus.msg_ready); end
    checks++; if (perm_rounds !== 4'(RB)) begin failures++; $display("FAIL mid_reset_rounds: got %0d expected %0d", perm_rounds, RB); end
    rst = 1'b0;
    cyc = 0;
    while (perm_done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++; if (perm_done !== 1'b1) begin failures++; $display("FAIL mid_late_done_timeout: got no perm_done expected pulse"); end
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b0 || bus.dig_valid !== 1'b0) begin failures++; $display("FAIL mid_late_done_ignored: got busy=%b dig_valid=%b expected 0/0", busy, bus.dig_valid); end
    checks++; if (perm_state_o !== TB_IV) begin failures++; $display("FAIL mid_late_done_state: got %h expected %h", perm_state_o, TB_IV); end
    eng_lat = 2;
    exp_d = ref_hash(m);
    run_hash(m, 1'b1, -1, 0, dig, lat, lp, sb, tmo);
    checks++; if (tmo || dig !== exp_d) begin failures++; $display("FAIL mid_rehash_digest: got %h expected %h", dig, exp_d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m[$];
    logic [255:0] dig, exp_d;
    logic [3:0] lp;
    int lat, sb, n; bit tmo;
    for (int t = 0; t < 8; t++) begin
      m.delete();
      n = (t == 0) ? 16 : $urandom_range(0, 40);
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      eng_lat = $urandom_range(1, 6);
      exp_d = ref_hash(m);
      run_hash(m, 1'b1, $urandom_range(0, 3), $urandom_range(0, 4), dig, lat, lp, sb, tmo);
      checks++; if (tmo || dig !== exp_d) begin failures++; $display("FAIL b2b_digest[%0d] len=%0d: got %h expected %h", t, n, dig, exp_d); end
      checks++; if (launch_mismatch(n) != 0) begin failures++; $display("FAIL b2b_launch_rounds[%0d]: got %0d bad launches expected 0", t, launch_mismatch(n)); end
      checks++; if (lp !== 4'b1000 || sb != 0) begin failures++; $display("FAIL b2b_last_stable[%0d]: got last=%b unstable=%0d expected 1000/0", t, lp, sb); end
    end
    checks++; if (overlap_errs != 0) begin failures++; $display("FAIL b2b_start_overlap: got %0d expected 0", overlap_errs); end
  endtask

  initial begin
    bus.msg_valid = 1'b0;
    bus.msg_data  = '0;
    bus.msg_last  = 1'b0;
    bus.msg_bytes = '0;
    bus.dig_ready = 1'b0;
    test_reset();
    test_empty();
    test_full_word();
    test_partial_garbage();
    test_dig_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
